// File: rtl/led_pkg.sv
// Shared mode encoding for the multi-channel LED driver.
package led_pkg;

   localparam int MODE_W = 2;

   typedef enum logic [MODE_W-1:0] {
      MODE_OFF     = 2'd0,
      MODE_ON      = 2'd1,
      MODE_BLINK   = 2'd2,
      MODE_BREATHE = 2'd3
   } led_mode_e;

endpackage

// File: rtl/led_channel.sv
// One LED channel: mode/period config, period counter, blink and breathe
// state, and the registered LED/tick outputs.
module led_channel
   import led_pkg::*;
#(
   parameter int               CNT_W      = 24,
   parameter int               PWM_W      = 8,
   parameter logic [CNT_W-1:0] RST_PERIOD = '0
) (
   input  logic              i_clk,
   input  logic              i_arst,
   input  logic              i_en,
   input  logic              i_wr,
   input  logic [MODE_W-1:0] i_wr_mode,
   input  logic [CNT_W-1:0]  i_wr_period,
   input  logic [PWM_W-1:0]  i_carrier,
   output logic              o_led,
   output logic              o_tick
);

   localparam logic [PWM_W-1:0] DUTY_MAX = {PWM_W{1'b1}};

   led_mode_e        mode_q,   mode_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic             blink_q,  blink_d;
   logic [PWM_W-1:0] duty_q,   duty_d;
   logic             down_q,   down_d;
   logic             led_q,    led_d;
   logic             tick_q,   tick_d;

   logic             running;
   logic [CNT_W-1:0] last_cnt;
   logic             wrap;

   assign running  = (mode_q == MODE_BLINK) || (mode_q == MODE_BREATHE);
   // A period of 0 behaves as 1, so the terminal count is 0 in both cases.
   assign last_cnt = (period_q == '0) ? '0 : period_q - CNT_W'(1);
   assign wrap     = running && i_en && (cnt_q == last_cnt);

   always_comb begin
      mode_d   = mode_q;
      period_d = period_q;
      cnt_d    = cnt_q;
      blink_d  = blink_q;
      duty_d   = duty_q;
      down_d   = down_q;
      tick_d   = 1'b0;
      led_d    = 1'b0;

      unique case (mode_q)
         MODE_OFF:     led_d = 1'b0;
         MODE_ON:      led_d = 1'b1;
         MODE_BLINK:   led_d = i_en ? blink_q : led_q;
         MODE_BREATHE: led_d = i_en ? (duty_q > i_carrier) : led_q;
         default:      led_d = 1'b0;
      endcase

      // A write on the wrap cycle takes priority and suppresses that tick.
      if (i_wr) begin
         mode_d   = led_mode_e'(i_wr_mode);
         period_d = i_wr_period;
         cnt_d    = '0;
         blink_d  = 1'b0;
         duty_d   = '0;
         down_d   = 1'b0;
      end else if (wrap) begin
         cnt_d  = '0;
         tick_d = 1'b1;
         if (mode_q == MODE_BLINK) begin
            blink_d = ~blink_q;
         end else if (!down_q) begin
            if (duty_q == DUTY_MAX) begin
               down_d = 1'b1;
               duty_d = DUTY_MAX - PWM_W'(1);
            end else begin
               duty_d = duty_q + PWM_W'(1);
            end
         end else begin
            if (duty_q == '0) begin
               down_d = 1'b0;
               duty_d = PWM_W'(1);
            end else begin
               duty_d = duty_q - PWM_W'(1);
            end
         end
      end else if (running && i_en) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (!running) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         mode_q   <= MODE_OFF;
         period_q <= RST_PERIOD;
         cnt_q    <= '0;
         blink_q  <= 1'b0;
         duty_q   <= '0;
         down_q   <= 1'b0;
         led_q    <= 1'b0;
         tick_q   <= 1'b0;
      end else begin
         mode_q   <= mode_d;
         period_q <= period_d;
         cnt_q    <= cnt_d;
         blink_q  <= blink_d;
         duty_q   <= duty_d;
         down_q   <= down_d;
         led_q    <= led_d;
         tick_q   <= tick_d;
      end
   end

   assign o_led  = led_q;
   assign o_tick = tick_q;

endmodule

// File: rtl/led_blinky_multi.sv
// Multi-channel LED driver: write decode, shared PWM carrier and one
// led_channel instance per LED.
module led_blinky_multi
   import led_pkg::*;
#(
   parameter int  CHANNELS       = 4,
   parameter int  CNT_W          = 24,
   parameter int  PWM_W          = 8,
   parameter int  DEFAULT_PERIOD = 25,
   localparam int CH_W           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                i_clk,
   input  logic                i_arst,
   input  logic                i_en,
   input  logic                i_wr_en,
   input  logic [CH_W-1:0]     i_wr_ch,
   input  logic [MODE_W-1:0]   i_wr_mode,
   input  logic [CNT_W-1:0]    i_wr_period,
   output logic [CHANNELS-1:0] o_led,
   output logic [CHANNELS-1:0] o_tick
);

   localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(DEFAULT_PERIOD);

   logic [PWM_W-1:0] pwm_q, pwm_d;
   logic             wr_ok;

   // The carrier free-runs across config writes so channels stay phase-aligned.
   always_comb begin
      pwm_d = pwm_q;
      if (i_en) pwm_d = pwm_q + PWM_W'(1);
   end

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) pwm_q <= '0;
      else        pwm_q <= pwm_d;
   end

   assign wr_ok = i_wr_en && (32'(i_wr_ch) < 32'(CHANNELS));

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      led_channel #(
         .CNT_W      (CNT_W),
         .PWM_W      (PWM_W),
         .RST_PERIOD (RST_PERIOD)
      ) u_ch (
         .i_clk       (i_clk),
         .i_arst      (i_arst),
         .i_en        (i_en),
         .i_wr        (wr_ok && (i_wr_ch == CH_W'(g))),
         .i_wr_mode   (i_wr_mode),
         .i_wr_period (i_wr_period),
         .i_carrier   (pwm_q),
         .o_led       (o_led[g]),
         .o_tick      (o_tick[g])
      );
   end

endmodule

// File: tb/tb_led_blinky_multi.sv
// Bench for led_blinky_multi: directed scenarios plus random traffic against a
// tick-count/triangle reference model. Five channels so out-of-range writes exist.
module tb_led_blinky_multi;

   localparam int CH  = 5;
   localparam int CW  = 24;
   localparam int PW  = 8;
   localparam int TRI = 2 * ((1 << PW) - 1);

   logic          clk = 1'b0;
   logic          arst = 1'b0;
   logic          en = 1'b0;
   logic          wr_en = 1'b0;
   logic [2:0]    wr_ch = '0;
   logic [1:0]    wr_mode = '0;
   logic [CW-1:0] wr_period = '0;
   logic [CH-1:0] o_led, o_tick;

   int checks = 0;
   int failures = 0;

   // Reference state: mode, period, position in period, and ticks since the last write.
   int m_mode[CH], m_per[CH], m_cnt[CH], m_ticks[CH];
   bit m_led[CH], m_tick[CH];
   int m_car;

   led_blinky_multi #(
      .CHANNELS(CH), .CNT_W(CW), .PWM_W(PW), .DEFAULT_PERIOD(25)
   ) dut (
      .i_clk(clk), .i_arst(arst), .i_en(en), .i_wr_en(wr_en), .i_wr_ch(wr_ch),
      .i_wr_mode(wr_mode), .i_wr_period(wr_period), .o_led(o_led), .o_tick(o_tick)
   );

   always #5 clk = ~clk;

   function automatic int tri_duty(int t);
      int r;
      r = t % TRI;
      return (r <= TRI / 2) ? r : TRI - r;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < CH; c++) begin
         m_mode[c] = 0; m_per[c] = 25; m_cnt[c] = 0; m_ticks[c] = 0;
         m_led[c] = 1'b0; m_tick[c] = 1'b0;
      end
      m_car = 0;
   endtask

   task automatic model_edge();
      bit nl;
      int peff;
      for (int c = 0; c < CH; c++) begin
         case (m_mode[c])
            0:       nl = 1'b0;
            1:       nl = 1'b1;
            2:       nl = en ? bit'(m_ticks[c] % 2) : m_led[c];
            default: nl = en ? (tri_duty(m_ticks[c]) > m_car) : m_led[c];
         endcase
         m_led[c]  = nl;
         m_tick[c] = 1'b0;
         if (wr_en && int'(wr_ch) == c) begin
            m_mode[c] = int'(wr_mode); m_per[c] = int'(wr_period);
            m_cnt[c] = 0; m_ticks[c] = 0;
         end else if (m_mode[c] >= 2 && en) begin
            peff = (m_per[c] == 0) ? 1 : m_per[c];
            if (m_cnt[c] == peff - 1) begin
               m_cnt[c] = 0; m_ticks[c]++; m_tick[c] = 1'b1;
            end else begin
               m_cnt[c]++;
            end
         end else if (m_mode[c] < 2) begin
            m_cnt[c] = 0;
         end
      end
      if (en) m_car = (m_car + 1) % (1 << PW);
   endtask

   task automatic check(input string tag);
      logic [CH-1:0] el, et;
      for (int c = 0; c < CH; c++) begin
         el[c] = m_led[c];
         et[c] = m_tick[c];
      end
      checks++;
      assert (o_led === el) else begin
         failures++;
         $error("FAIL %s led got=%b exp=%b t=%0t", tag, o_led, el, $time);
      end
      checks++;
      assert (o_tick === et) else begin
         failures++;
         $error("FAIL %s tick got=%b exp=%b t=%0t", tag, o_tick, et, $time);
      end
   endtask

   task automatic cycle(input string tag);
      model_edge();
      @(posedge clk);
      #1;
      check(tag);
   endtask

   task automatic write(input int ch, input int mode, input int per, input string tag);
      wr_en = 1'b1; wr_ch = 3'(ch); wr_mode = 2'(mode); wr_period = CW'(per);
      cycle(tag);
      wr_en = 1'b0;
   endtask

   task automatic run(input int n, input string tag);
      repeat (n) cycle(tag);
   endtask

   initial begin
      int guard;
      model_reset();
      #2 arst = 1'b1;
      #1;
      check("reset_async");
      @(posedge clk); #1;
      check("reset_hold");
      arst = 1'b0;
      en = 1'b1;
      run(6, "idle");

      write(0, 2, 4, "blink4_wr");
      run(24, "blink4");

      write(1, 2, 0, "blink0_wr");
      run(10, "blink0");

      // Freeze mid-phase, then resume with the remaining count.
      run(2, "pre_freeze");
      en = 1'b0;
      run(10, "frozen");
      en = 1'b1;
      run(12, "resume");

      write(2, 3, 1, "breathe_wr");
      run(600, "breathe");

      // Out-of-range writes must not disturb anything.
      write(5, 1, 3, "bad_ch5");
      write(7, 3, 0, "bad_ch7");
      run(4, "after_bad");

      // ON written on the very edge ch0 would wrap: no tick, LED on one edge later.
      write(0, 2, 4, "tickwr_setup");
      guard = 0;
      while (m_cnt[0] != 3 && guard < 20) begin
         cycle("tickwr_wait");
         guard++;
      end
      checks++;
      assert (guard < 20) else begin
         failures++;
         $error("FAIL tickwr_bound got=%0d exp=<20", guard);
      end
      write(0, 1, 4, "tickwr_on");
      checks++;
      assert (o_tick[0] === 1'b0) else begin
         failures++;
         $error("FAIL tickwr_notick got=%b exp=0", o_tick[0]);
      end
      cycle("tickwr_next");
      checks++;
      assert (o_led[0] === 1'b1) else begin
         failures++;
         $error("FAIL tickwr_led got=%b exp=1", o_led[0]);
      end

      for (int i = 0; i < 500; i++) begin
         en = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 7) == 0)
            write(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 5)), "rand_wr");
         else
            cycle("rand");
      end

      // Async reset mid-blink must clear outputs without a clock edge.
      en = 1'b1;
      write(3, 2, 2, "rst_setup");
      guard = 0;
      while (!m_led[3] && guard < 10) begin
         cycle("rst_wait");
         guard++;
      end
      #3 arst = 1'b1;
      model_reset();
      #1;
      check("reset_mid");
      @(posedge clk); #1;
      arst = 1'b0;
      run(8, "post_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
